// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient sequencer.
package fir_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
  typedef enum logic {MODE_IMPULSE, MODE_PASS} mode_e;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
endpackage

// File: rtl/coef_ram.sv
// Coefficient store: one write port, one synchronous read port, contents not reset.
module coef_ram #(
  parameter int DW    = 32,
  parameter int NTAPS = 103,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [NTAPS];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;
endmodule

// File: rtl/fir_coef_sequencer.sv
// Loads NTAPS host-written coefficients into a serial-load FIR, then drives its
// sample input with a periodic impulse or a registered copy of live samples.
module fir_coef_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int            DW          = 32,
  parameter int            NTAPS       = 103,
  parameter int            AW          = $clog2(NTAPS),
  parameter int            PERIOD      = 201,
  parameter logic [DW-1:0] IMPULSE_VAL = DW'(FP_ONE)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic          i_cfg_wr,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [DW-1:0] i_cfg_data,
  input  logic [DW-1:0] i_sample,
  output logic          o_tap_wr,
  output logic [DW-1:0] o_tap,
  output logic [DW-1:0] o_sample,
  output logic          o_ce,
  output logic          o_busy,
  output logic          o_loaded,
  output logic          o_err
);
  localparam int            CW        = $clog2(PERIOD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic          start_q;
  logic [AW-1:0] addr_q, addr_d;
  logic          issue_q, issue_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tap_wr_q, tap_wr_d;
  logic [DW-1:0] tap_q, tap_d;
  logic [DW-1:0] sample_q, sample_d;
  logic          ce_q, ce_d;
  logic          busy_q, busy_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data;
  logic          start_edge, rd_en, cfg_ok, ram_we;

  assign start_edge = i_start & ~start_q;
  assign rd_en      = (state_q == LOAD) & issue_q;
  assign cfg_ok     = (state_q == IDLE) && (i_cfg_addr <= LAST_ADDR);
  assign ram_we     = i_cfg_wr & cfg_ok & ~i_reset;

  coef_ram #(.DW(DW), .NTAPS(NTAPS), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_data),
    .i_re    (rd_en),
    .i_raddr (addr_q),
    .o_rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    err_d     = err_q | (i_cfg_wr & ~cfg_ok);
    // Read pipeline: address -> RAM register -> tap output register.
    rd_vld_d  = rd_en;
    rd_last_d = rd_en && (addr_q == LAST_ADDR);
    tap_wr_d  = rd_vld_q;
    tap_d     = rd_vld_q ? rd_data : '0;
    sample_d  = '0;
    ce_d      = 1'b0;
    unique case (state_q)
      IDLE: if (start_edge) begin
        state_d  = LOAD;
        addr_d   = '0;
        issue_d  = 1'b1;
        loaded_d = 1'b0;
      end
      LOAD: begin
        if (rd_en) begin
          if (addr_q == LAST_ADDR) issue_d = 1'b0;
          else                     addr_d  = addr_q + 1'b1;
        end
        if (rd_last_q) begin
          state_d  = RUN;
          loaded_d = 1'b1;
          cnt_d    = '0;
          mode_d   = mode_e'(i_mode);
        end
      end
      RUN: if (!i_start) begin
        state_d = IDLE;
      end else begin
        ce_d = i_ce;
        if (mode_q == MODE_PASS) begin
          sample_d = i_ce ? i_sample : sample_q;
        end else begin
          sample_d = (i_ce && cnt_q == PER_LAST) ? IMPULSE_VAL : '0;
          if (i_ce) cnt_d = (cnt_q == PER_LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_IMPULSE;
      start_q   <= 1'b1;
      addr_q    <= '0;
      issue_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      cnt_q     <= '0;
      tap_wr_q  <= 1'b0;
      tap_q     <= '0;
      sample_q  <= '0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      start_q   <= i_start;
      addr_q    <= addr_d;
      issue_q   <= issue_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      cnt_q     <= cnt_d;
      tap_wr_q  <= tap_wr_d;
      tap_q     <= tap_d;
      sample_q  <= sample_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
    end
  end

  assign o_tap_wr = tap_wr_q;
  assign o_tap    = tap_q;
  assign o_sample = sample_q;
  assign o_ce     = ce_q;
  assign o_busy   = busy_q;
  assign o_loaded = loaded_q;
  assign o_err    = err_q;
endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed/randomized bench for fir_coef_sequencer against a cycle-level behavioural model.
module tb_fir_coef_sequencer;
  localparam int          NT  = 103;
  localparam int          PER = 201;
  localparam logic [31:0] IMP = 32'h3F80_0000;

  logic        clk = 1'b0;
  logic        i_reset, i_ce, i_start, i_mode, i_cfg_wr;
  logic [6:0]  i_cfg_addr;
  logic [31:0] i_cfg_data, i_sample;
  logic        o_tap_wr, o_ce, o_busy, o_loaded, o_err;
  logic [31:0] o_tap, o_sample;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [NT];
  logic        err_m = 1'b0;

  fir_coef_sequencer dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_start(i_start), .i_mode(i_mode),
    .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .i_sample(i_sample), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_sample(o_sample),
    .o_ce(o_ce), .o_busy(o_busy), .o_loaded(o_loaded), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Raise start (optionally with a same-cycle write) and follow the load;
  // stop_at > 0 abandons the load after that many post-edge cycles.
  task automatic do_load(input bit wr0, input logic [31:0] v0, input int stop_at);
    i_start = 1'b1;
    if (wr0) begin
      i_cfg_wr = 1'b1; i_cfg_addr = 7'd0; i_cfg_data = v0; mem[0] = v0;
    end
    tick();
    i_cfg_wr = 1'b0;
    chk1("load_busy", o_busy, 1'b1);
    chk1("load_loaded_clr", o_loaded, 1'b0);
    for (int i = 1; i <= NT + 1; i++) begin
      if (stop_at > 0 && i > stop_at) break;
      tick();
      chk1("tap_wr", o_tap_wr, i >= 2);
      if (i >= 2) chk32("tap", o_tap, mem[i-2]);
      chk1("loaded", o_loaded, i == NT + 1);
      chk1("load_busy_hold", o_busy, 1'b1);
    end
  endtask

  // Run for n cycles with mode already latched; i_mode is scrambled to prove the latch.
  task automatic do_run(input bit pass, input int n, input bit rnd_ce, output int imps);
    int          en   = 0;
    logic [31:0] prev = '0;
    logic [31:0] exp, s;
    logic        ce;
    imps = 0;
    for (int c = 0; c < n; c++) begin
      ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      s  = $urandom;
      i_ce = ce; i_sample = s; i_mode = 1'($urandom_range(0, 1));
      tick();
      chk1("run_ce", o_ce, ce);
      chk1("run_busy", o_busy, 1'b1);
      if (pass) begin
        if (ce) prev = s;
        exp = prev;
      end else begin
        if (ce) en++;
        exp = (ce && (en % PER) == 0) ? IMP : 32'h0;
      end
      chk32(pass ? "pass_sample" : "imp_sample", o_sample, exp);
      if (o_sample == IMP) imps++;
    end
  endtask

  task automatic do_stop();
    i_start = 1'b0; i_ce = 1'b1;
    tick();
    chk32("stop_sample", o_sample, 32'h0);
    chk1("stop_ce", o_ce, 1'b0);
    chk1("stop_busy", o_busy, 1'b0);
    chk1("stop_loaded", o_loaded, 1'b1);
    chk1("stop_err", o_err, err_m);
  endtask

  initial begin
    int imps;
    i_reset = 1'b1; i_ce = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_cfg_wr = 1'b0;
    i_cfg_addr = '0; i_cfg_data = '0; i_sample = '0;
    tick(); tick();
    chk1("rst_tap_wr", o_tap_wr, 1'b0);
    chk32("rst_tap", o_tap, 32'h0);
    chk32("rst_sample", o_sample, 32'h0);
    chk1("rst_ce", o_ce, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_loaded", o_loaded, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    i_reset = 1'b0;
    tick();

    // Preload ramp k+1.
    for (int k = 0; k < NT; k++) begin
      i_cfg_wr = 1'b1; i_cfg_addr = 7'(k); i_cfg_data = 32'(k + 1); mem[k] = 32'(k + 1);
      tick();
    end
    i_cfg_wr = 1'b0;
    tick();
    chk1("preload_err", o_err, 1'b0);

    // Impulse mode, i_ce always high.
    i_mode = 1'b0;
    do_load(1'b0, '0, 0);
    do_run(1'b0, 610, 1'b0, imps);
    chk32("imp_count", 32'(imps), 32'd3);
    do_stop();

    // Random coefficients, impulse mode with 50% i_ce.
    for (int k = 0; k < NT; k++) begin
      i_cfg_wr = 1'b1; i_cfg_addr = 7'(k); i_cfg_data = $urandom; mem[k] = i_cfg_data;
      tick();
    end
    i_cfg_wr = 1'b0;
    i_mode = 1'b0;
    do_load(1'b0, '0, 0);
    do_run(1'b0, 500, 1'b1, imps);
    do_stop();

    // Passthrough with random samples and i_ce.
    i_mode = 1'b1;
    do_load(1'b0, '0, 0);
    do_run(1'b1, 200, 1'b1, imps);
    do_stop();

    // Illegal writes: during RUN and out-of-range address in IDLE.
    i_mode = 1'b1;
    do_load(1'b0, '0, 0);
    i_cfg_wr = 1'b1; i_cfg_addr = 7'd5; i_cfg_data = 32'hDEAD_BEEF; i_ce = 1'b0;
    tick();
    err_m = 1'b1;
    i_cfg_wr = 1'b0;
    chk1("err_run_write", o_err, 1'b1);
    do_stop();
    i_cfg_wr = 1'b1; i_cfg_addr = 7'd103; i_cfg_data = 32'h1234_5678;
    tick();
    i_cfg_wr = 1'b0;
    chk1("err_oob_write", o_err, 1'b1);
    tick();
    chk1("err_sticky", o_err, 1'b1);
    i_mode = 1'b0;
    do_load(1'b0, '0, 0);
    chk1("err_after_reload", o_err, 1'b1);
    do_stop();

    // Reset at tap 50 with start held high.
    do_load(1'b0, '0, 51);
    i_reset = 1'b1;
    tick();
    err_m = 1'b0;
    i_reset = 1'b0;
    chk1("rst_mid_tap_wr", o_tap_wr, 1'b0);
    chk1("rst_mid_busy", o_busy, 1'b0);
    chk1("rst_mid_loaded", o_loaded, 1'b0);
    chk1("rst_mid_err", o_err, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk1("held_start_busy", o_busy, 1'b0);
      chk1("held_start_tap_wr", o_tap_wr, 1'b0);
    end
    i_start = 1'b0;
    tick();
    do_load(1'b0, '0, 0);
    do_stop();

    // Same-cycle write to address 0 and start edge.
    tick();
    do_load(1'b1, 32'h0000_AAAA, 0);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
